screen_sequencer: RTL and testbench

Game-flow controller that sequences the video output mux between title, play and win screens. It tracks each player's remaining lives from one-cycle hit pulses. It drives the mux's `player_screen` select and a one-cycle `reset_screen` pulse that re-initialises tanks and map at every round boundary. Win screens are held for a fixed number of video frames, counted on a per-frame tick, before returning to the title.

---
 rtl/screen_sequencer.sv | 126 ++++++++++++
 tb/tb_screen_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_sequencer.sv
// Game-flow controller: steps the video mux through title, play and win screens,
// tracks per-player lives from hit pulses and emits a round-boundary reset pulse.
module screen_sequencer #(
    parameter int LIVES       = 3,
    parameter int HOLD_FRAMES = 180
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       frame_tick,
    input  logic       hit_p1,
    input  logic       hit_p2,
    output logic [1:0] player_screen,
    output logic       reset_screen,
    output logic       game_active,
    output logic [1:0] lives_p1,
    output logic [1:0] lives_p2
);

    typedef enum logic [1:0] {TITLE, PLAY, WIN1, WIN2} state_t;

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);

    state_t     state, state_nx;
    logic [1:0] lives1_nx, lives2_nx;
    logic [1:0] dec1, dec2;
    logic [7:0] hold_cnt, hold_nx;
    logic [1:0] screen_nx;
    logic       reset_screen_nx;
    logic       start_d, start_armed, start_rise;

    // NOTE: every register below uses <= so all of them update from the same
    // pre-edge values; the combinational block uses = with defaults first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= TITLE;
            lives_p1      <= 2'd0;
            lives_p2      <= 2'd0;
            hold_cnt      <= 8'd0;
            player_screen <= 2'b00;
            reset_screen  <= 1'b0;
            game_active   <= 1'b0;
            start_d       <= 1'b0;
            start_armed   <= 1'b0;
            start_rise    <= 1'b0;
        end else begin
            state         <= state_nx;
            lives_p1      <= lives1_nx;
            lives_p2      <= lives2_nx;
            hold_cnt      <= hold_nx;
            player_screen <= screen_nx;
            reset_screen  <= reset_screen_nx;
            game_active   <= (state_nx == PLAY);
            start_d       <= start;
            // A switch left high through reset must be seen low before it can start a game.
            start_armed   <= start_armed | ~start;
            start_rise    <= start & ~start_d & start_armed;
        end
    end

    assign dec1 = (hit_p1 && lives_p1 != 2'd0) ? lives_p1 - 2'd1 : lives_p1;
    assign dec2 = (hit_p2 && lives_p2 != 2'd0) ? lives_p2 - 2'd1 : lives_p2;

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_nx        = state;
        lives1_nx       = lives_p1;
        lives2_nx       = lives_p2;
        hold_nx         = hold_cnt;
        reset_screen_nx = 1'b0;

        case (state)
            TITLE: begin
                if (start_rise) begin
                    state_nx        = PLAY;
                    lives1_nx       = LIVES_INIT;
                    lives2_nx       = LIVES_INIT;
                    reset_screen_nx = 1'b1;
                end
            end
            PLAY: begin
                if (!start) begin
                    // Abort wins over any hit in the same cycle.
                    state_nx        = TITLE;
                    reset_screen_nx = 1'b1;
                end else if (dec1 == 2'd0 && dec2 == 2'd0) begin
                    lives1_nx       = 2'd1;
                    lives2_nx       = 2'd1;
                    reset_screen_nx = 1'b1;
                end else begin
                    lives1_nx = dec1;
                    lives2_nx = dec2;
                    if (dec2 == 2'd0) begin
                        state_nx = WIN1;
                        hold_nx  = 8'd0;
                    end else if (dec1 == 2'd0) begin
                        state_nx = WIN2;
                        hold_nx  = 8'd0;
                    end
                end
            end
            WIN1, WIN2: begin
                if (frame_tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_nx        = TITLE;
                        lives1_nx       = 2'd0;
                        lives2_nx       = 2'd0;
                        hold_nx         = 8'd0;
                        reset_screen_nx = 1'b1;
                    end else begin
                        hold_nx = hold_cnt + 8'd1;
                    end
                end
            end
            default: state_nx = TITLE;
        endcase

        case (state_nx)
            WIN1:    screen_nx = 2'b01;
            WIN2:    screen_nx = 2'b10;
            default: screen_nx = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_screen_sequencer.sv
// Self-checking bench for screen_sequencer: directed scenarios plus random traffic,
// all compared against a cycle-level game model written from the game rules.
module tb_screen_sequencer;

    localparam int LIVES = 3;
    localparam int HOLD  = 180;

    localparam int M_TITLE = 0;
    localparam int M_PLAY  = 1;
    localparam int M_WIN1  = 2;
    localparam int M_WIN2  = 3;

    logic       clk;
    logic       reset, start, frame_tick, hit_p1, hit_p2;
    logic [1:0] player_screen, lives_p1, lives_p2;
    logic       reset_screen, game_active;

    int vectors;
    int miscompares;

    // Reference model state
    int m_mode, m_l1, m_l2, m_left;
    bit m_rs, m_prev, m_rise, m_armed;

    screen_sequencer #(.LIVES(LIVES), .HOLD_FRAMES(HOLD)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .frame_tick   (frame_tick),
        .hit_p1       (hit_p1),
        .hit_p2       (hit_p2),
        .player_screen(player_screen),
        .reset_screen (reset_screen),
        .game_active  (game_active),
        .lives_p1     (lives_p1),
        .lives_p2     (lives_p2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] obs_vec();
        return {player_screen, reset_screen, game_active, lives_p1, lives_p2};
    endfunction

    function automatic logic [7:0] exp_vec();
        logic [1:0] ps;
        ps = (m_mode == M_WIN1) ? 2'b01 : (m_mode == M_WIN2) ? 2'b10 : 2'b00;
        return {ps, m_rs, (m_mode == M_PLAY), 2'(m_l1), 2'(m_l2)};
    endfunction

    function automatic string fmt(input logic [7:0] v);
        return $sformatf("ps=%b rs=%b ga=%b l1=%0d l2=%0d", v[7:6], v[5], v[4], v[3:2], v[1:0]);
    endfunction

    // Game rules applied to one clock edge.
    task automatic model_step(input logic r, input logic s, input logic t,
                              input logic h1, input logic h2);
        int n1, n2;
        if (r) begin
            m_mode = M_TITLE; m_l1 = 0; m_l2 = 0; m_left = 0;
            m_rs = 0; m_prev = 0; m_rise = 0; m_armed = 0;
            return;
        end
        m_rs = 0;
        case (m_mode)
            M_TITLE: if (m_rise) begin
                m_mode = M_PLAY; m_l1 = LIVES; m_l2 = LIVES; m_rs = 1;
            end
            M_PLAY: begin
                if (!s) begin
                    m_mode = M_TITLE; m_rs = 1;
                end else begin
                    n1 = (h1 && m_l1 > 0) ? m_l1 - 1 : m_l1;
                    n2 = (h2 && m_l2 > 0) ? m_l2 - 1 : m_l2;
                    if (n1 == 0 && n2 == 0) begin
                        m_l1 = 1; m_l2 = 1; m_rs = 1;
                    end else begin
                        m_l1 = n1; m_l2 = n2;
                        if (n2 == 0)      begin m_mode = M_WIN1; m_left = HOLD; end
                        else if (n1 == 0) begin m_mode = M_WIN2; m_left = HOLD; end
                    end
                end
            end
            default: if (t) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_mode = M_TITLE; m_l1 = 0; m_l2 = 0; m_rs = 1;
                end
            end
        endcase
        m_rise  = s && !m_prev && m_armed;
        m_armed = m_armed || !s;
        m_prev  = s;
    endtask

    // Apply one cycle of inputs, clock it, advance the model, settle past the edge.
    task automatic cycle(input logic r, input logic s, input logic t,
                         input logic h1, input logic h2);
        reset = r; start = s; frame_tick = t; hit_p1 = h1; hit_p2 = h2;
        @(posedge clk);
        model_step(r, s, t, h1, h2);
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 1, 1, 1);
        vectors++;
        if (obs_vec() !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_values: got %s want %s", fmt(obs_vec()), fmt(8'h00));
        end
        cycle(0, 0, 0, 0, 0);
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_idle: got %s want %s", fmt(obs_vec()), fmt(exp_vec()));
        end
    endtask

    task automatic test_start();
        cycle(0, 1, 0, 0, 0);
        vectors++;
        if (obs_vec() !== 8'h00) begin
            miscompares++;
            $display("FAIL start_edge1: got %s want %s", fmt(obs_vec()), fmt(8'h00));
        end
        cycle(0, 1, 0, 0, 0);
        vectors++;
        if (obs_vec() !== 8'b00_1_1_11_11) begin
            miscompares++;
            $display("FAIL start_play: got %s want %s", fmt(obs_vec()), fmt(8'b00_1_1_11_11));
        end
        cycle(0, 1, 0, 0, 0);
        vectors++;
        if (obs_vec() !== 8'b00_0_1_11_11) begin
            miscompares++;
            $display("FAIL start_pulse_end: got %s want %s", fmt(obs_vec()), fmt(8'b00_0_1_11_11));
        end
    endtask

    task automatic test_p1_victory();
        for (int k = 1; k <= 3; k++) begin
            // The final hit carries a frame tick that must not count toward the hold.
            cycle(0, 1, (k == 3), 0, 1);
            vectors++;
            if (lives_p2 !== 2'(3 - k) || obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL victory_hit%0d: got %s want %s", k, fmt(obs_vec()), fmt(exp_vec()));
            end
            if (k == 3) begin
                vectors++;
                if (player_screen !== 2'b01) begin
                    miscompares++;
                    $display("FAIL victory_screen: got %b want 01", player_screen);
                end
            end
            cycle(0, 1, 0, 0, 0);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL victory_idle%0d: got %s want %s", k, fmt(obs_vec()), fmt(exp_vec()));
            end
        end
        for (int t = 1; t <= HOLD; t++) begin
            repeat ($urandom_range(0, 2)) cycle(0, 1, 0, 0, 0);
            cycle(0, 1, 1, 0, 0);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL victory_tick%0d: got %s want %s", t, fmt(obs_vec()), fmt(exp_vec()));
            end
        end
        vectors++;
        if (obs_vec() !== 8'b00_1_0_00_00) begin
            miscompares++;
            $display("FAIL victory_exit: got %s want %s", fmt(obs_vec()), fmt(8'b00_1_0_00_00));
        end
        cycle(0, 1, 0, 0, 0);
        vectors++;
        if (obs_vec() !== 8'b00_0_0_00_00) begin
            miscompares++;
            $display("FAIL victory_title: got %s want %s", fmt(obs_vec()), fmt(8'b00_0_0_00_00));
        end
    endtask

    task automatic test_sudden_death();
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            cycle(0, 1, 0, 1, 0);
            cycle(0, 1, 0, 0, 1);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL sudden_setup%0d: got %s want %s", k, fmt(obs_vec()), fmt(exp_vec()));
            end
        end
        cycle(0, 1, 0, 1, 1);
        vectors++;
        if (obs_vec() !== 8'b00_1_1_01_01) begin
            miscompares++;
            $display("FAIL sudden_death: got %s want %s", fmt(obs_vec()), fmt(8'b00_1_1_01_01));
        end
        cycle(0, 1, 0, 0, 0);
        vectors++;
        if (obs_vec() !== 8'b00_0_1_01_01) begin
            miscompares++;
            $display("FAIL sudden_after: got %s want %s", fmt(obs_vec()), fmt(8'b00_0_1_01_01));
        end
    endtask

    task automatic test_abort();
        cycle(0, 0, 0, 1, 0);
        vectors++;
        if (obs_vec() !== 8'b00_1_0_01_01) begin
            miscompares++;
            $display("FAIL abort: got %s want %s", fmt(obs_vec()), fmt(8'b00_1_0_01_01));
        end
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        vectors++;
        if (obs_vec() !== 8'b00_0_0_01_01) begin
            miscompares++;
            $display("FAIL abort_title: got %s want %s", fmt(obs_vec()), fmt(8'b00_0_0_01_01));
        end
        cycle(0, 1, 0, 0, 0);
        vectors++;
        if (obs_vec() !== 8'b00_1_1_11_11) begin
            miscompares++;
            $display("FAIL abort_restart: got %s want %s", fmt(obs_vec()), fmt(8'b00_1_1_11_11));
        end
    endtask

    task automatic test_ignored();
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 1);
        vectors++;
        if (obs_vec() !== 8'b00_0_0_11_11) begin
            miscompares++;
            $display("FAIL ignore_title_hits: got %s want %s", fmt(obs_vec()), fmt(8'b00_0_0_11_11));
        end
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        repeat (3) cycle(0, 1, 0, 1, 0);
        vectors++;
        if (obs_vec() !== 8'b10_0_0_00_11) begin
            miscompares++;
            $display("FAIL ignore_win2_entry: got %s want %s", fmt(obs_vec()), fmt(8'b10_0_0_00_11));
        end
        for (int t = 1; t <= HOLD; t++) begin
            // Hits at zero lives, hits on the winner and start toggles all ride along.
            cycle(0, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cycle(0, 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)), 0);
            vectors++;
            if (t < HOLD && obs_vec() !== 8'b10_0_0_00_11) begin
                miscompares++;
                $display("FAIL ignore_win2_tick%0d: got %s want %s", t, fmt(obs_vec()), fmt(8'b10_0_0_00_11));
            end else if (t == HOLD && obs_vec() !== 8'b00_1_0_00_00) begin
                miscompares++;
                $display("FAIL ignore_win2_exit: got %s want %s", fmt(obs_vec()), fmt(8'b00_1_0_00_00));
            end
        end
    endtask

    task automatic test_reset_mid_win();
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        repeat (3) cycle(0, 1, 0, 0, 1);
        repeat (100) cycle(0, 1, 1, 0, 0);
        vectors++;
        if (obs_vec() !== 8'b01_0_0_11_00) begin
            miscompares++;
            $display("FAIL midwin_state: got %s want %s", fmt(obs_vec()), fmt(8'b01_0_0_11_00));
        end
        cycle(1, 1, 1, 1, 1);
        vectors++;
        if (obs_vec() !== 8'h00) begin
            miscompares++;
            $display("FAIL midwin_reset: got %s want %s", fmt(obs_vec()), fmt(8'h00));
        end
        for (int k = 0; k < 5; k++) begin
            cycle(0, 1, 0, 0, 0);
            vectors++;
            if (obs_vec() !== 8'h00) begin
                miscompares++;
                $display("FAIL held_start%0d: got %s want %s", k, fmt(obs_vec()), fmt(8'h00));
            end
        end
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        vectors++;
        if (obs_vec() !== 8'b00_1_1_11_11) begin
            miscompares++;
            $display("FAIL rearm_start: got %s want %s", fmt(obs_vec()), fmt(8'b00_1_1_11_11));
        end
        // A fresh win must again take the full hold, proving the counter was cleared.
        repeat (3) cycle(0, 1, 0, 0, 1);
        for (int t = 1; t <= HOLD; t++) begin
            cycle(0, 1, 1, 0, 0);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL rewin_tick%0d: got %s want %s", t, fmt(obs_vec()), fmt(exp_vec()));
            end
        end
    endtask

    task automatic test_random();
        logic s;
        s = 1'b0;
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) s = ~s;
            cycle(($urandom_range(0, 299) == 0), s, ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random%0d: got %s want %s", i, fmt(obs_vec()), fmt(exp_vec()));
            end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b1; start = 1'b0; frame_tick = 1'b0; hit_p1 = 1'b0; hit_p2 = 1'b0;
        m_mode = M_TITLE; m_l1 = 0; m_l2 = 0; m_left = 0;
        m_rs = 0; m_prev = 0; m_rise = 0; m_armed = 0;
        test_reset();
        test_start();
        test_p1_victory();
        test_sudden_death();
        test_abort();
        test_ignored();
        test_reset_mid_win();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
